// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detector for the five-stage core. It compares D-stage source registers and
// their use deadlines (Tuse) against the E/M destinations and their produce deadlines (Tnew).
// It also tracks the multi-cycle mult/div unit with a busy counter. The single stall output
// freezes PC/D and bubbles E.
module hazard_stall_unit #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic       D_md,
  input  logic [4:0] E_wa,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wa,
  input  logic [1:0] M_tnew,
  input  logic       E_md_start,
  input  logic       E_md_op,
  output logic       stall,
  output logic       md_busy,
  output logic       md_done
);

  localparam int unsigned MaxCyc = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  logic hit_rs_e, hit_rs_m, hit_rt_e, hit_rt_m;
  logic stall_reg, stall_md;

  // Register hazards: a stall is needed only when the producer cannot forward in time.
  // Register $0 never hazards. A Tuse of 3 marks an unread operand and can never lose
  // against a Tnew.
  always_comb begin
    hit_rs_e  = (D_rs != 5'd0) && (D_rs == E_wa) && (E_tnew > D_rs_tuse);
    hit_rs_m  = (D_rs != 5'd0) && (D_rs == M_wa) && (M_tnew > D_rs_tuse);
    hit_rt_e  = (D_rt != 5'd0) && (D_rt == E_wa) && (E_tnew > D_rt_tuse);
    hit_rt_m  = (D_rt != 5'd0) && (D_rt == M_wa) && (M_tnew > D_rt_tuse);
    stall_reg = hit_rs_e | hit_rs_m | hit_rt_e | hit_rt_m;
  end

  // Mult/div counter next state. A start always (re)loads, even while busy.
  // md_done is raised when the count leaves 1 with no reload.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (E_md_start) begin
      cnt_d = E_md_op ? CntW'(DIV_CYC) : CntW'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - CntW'(1);
      done_d = (cnt_q == CntW'(1));
    end
  end

  // Counter and done-pulse registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Outputs. An md instruction in D waits while the unit is starting or busy.
  // Stall is forced low during reset.
  always_comb begin
    md_busy  = (cnt_q != '0);
    md_done  = done_q;
    stall_md = D_md && (E_md_start || md_busy);
    stall    = rst_n && (stall_reg || stall_md);
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: table of combinational hazard vectors plus
// hand-written mult, div and reset-mid-div sequences.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] D_rs, D_rt, E_wa, M_wa;
  logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic       D_md, E_md_start, E_md_op;
  logic       stall, md_busy, md_done;

  int checks   = 0;
  int failures = 0;

  hazard_stall_unit #(
    .MULT_CYC(5),
    .DIV_CYC (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .D_rs      (D_rs),
    .D_rt      (D_rt),
    .D_rs_tuse (D_rs_tuse),
    .D_rt_tuse (D_rt_tuse),
    .D_md      (D_md),
    .E_wa      (E_wa),
    .E_tnew    (E_tnew),
    .M_wa      (M_wa),
    .M_tnew    (M_tnew),
    .E_md_start(E_md_start),
    .E_md_op   (E_md_op),
    .stall     (stall),
    .md_busy   (md_busy),
    .md_done   (md_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] d_rs;
    logic [4:0] d_rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic       d_md;
    logic [4:0] e_wa;
    logic [1:0] e_tnew;
    logic [4:0] m_wa;
    logic [1:0] m_tnew;
    logic       exp_stall;
  } vec_t;

  localparam int NumVec = 13;
  vec_t vecs[NumVec];

  function automatic vec_t mk(int rs, int rt, int rs_tu, int rt_tu, int md, int ewa, int etn,
                              int mwa, int mtn, int exp);
    vec_t v;
    v.d_rs      = 5'(rs);
    v.d_rt      = 5'(rt);
    v.rs_tuse   = 2'(rs_tu);
    v.rt_tuse   = 2'(rt_tu);
    v.d_md      = 1'(md);
    v.e_wa      = 5'(ewa);
    v.e_tnew    = 2'(etn);
    v.m_wa      = 5'(mwa);
    v.m_tnew    = 2'(mtn);
    v.exp_stall = 1'(exp);
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    D_rs       = v.d_rs;
    D_rt       = v.d_rt;
    D_rs_tuse  = v.rs_tuse;
    D_rt_tuse  = v.rt_tuse;
    D_md       = v.d_md;
    E_wa       = v.e_wa;
    E_tnew     = v.e_tnew;
    M_wa       = v.m_wa;
    M_tnew     = v.m_tnew;
    E_md_start = 1'b0;
    E_md_op    = 1'b0;
  endtask

  // Quiet register state: no operand read, no destinations.
  task automatic quiet_regs();
    D_rs = 5'd0; D_rt = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
  endtask

  initial begin
    //          rs rt rsT rtT md Ewa Etn Mwa Mtn exp
    vecs[0]  = mk(5, 0, 1, 3, 0, 5, 2, 0, 0, 1);  // load-use via E
    vecs[1]  = mk(5, 0, 1, 3, 0, 0, 0, 5, 1, 0);  // load now in M, forwardable
    vecs[2]  = mk(0, 0, 0, 3, 0, 0, 2, 0, 0, 0);  // $0 immunity
    vecs[3]  = mk(0, 7, 0, 3, 0, 7, 2, 0, 0, 0);  // rt not read
    vecs[4]  = mk(0, 9, 3, 0, 0, 0, 0, 9, 1, 1);  // branch after ALU
    vecs[5]  = mk(0, 9, 3, 0, 0, 0, 0, 9, 0, 0);  // ALU result ready
    vecs[6]  = mk(0, 3, 3, 0, 0, 3, 1, 0, 0, 1);  // rt hit in E
    vecs[7]  = mk(0, 3, 3, 1, 0, 3, 1, 0, 0, 0);  // Tnew == Tuse, no stall
    vecs[8]  = mk(4, 0, 0, 3, 0, 4, 0, 4, 1, 1);  // E and M same reg, M hits
    vecs[9]  = mk(4, 0, 1, 3, 0, 4, 2, 4, 0, 1);  // E and M same reg, E hits
    vecs[10] = mk(6, 0, 0, 3, 0, 5, 2, 5, 1, 0);  // different register
    vecs[11] = mk(0, 0, 3, 3, 1, 0, 0, 0, 0, 0);  // md instr, unit idle
    vecs[12] = mk(0, 8, 3, 2, 0, 0, 0, 8, 3, 1);  // M_tnew 3 taken as given

    rst_n = 1'b0;
    drive_vec(vecs[0]);
    #2;
    chk("reset_stall_low", stall, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("reset_busy", md_busy, 1'b0);
    chk("reset_done", md_done, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < NumVec; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #2;
      chk($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
    end

    // Mult with md instruction held in D.
    @(negedge clk);
    quiet_regs();
    D_md = 1'b1; E_md_start = 1'b1; E_md_op = 1'b0;
    #2;
    chk("mult_c0_stall", stall, 1'b1);
    chk("mult_c0_busy", md_busy, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      E_md_start = 1'b0;
      #2;
      chk($sformatf("mult_c%0d_stall", c), stall, (c <= 5));
      chk($sformatf("mult_c%0d_busy", c), md_busy, (c <= 5));
      chk($sformatf("mult_c%0d_done", c), md_done, (c == 6));
    end

    // Div with a non-md instruction; md instruction appears at busy cycle 4.
    @(negedge clk);
    D_md = 1'b0; E_md_start = 1'b1; E_md_op = 1'b1;
    #2;
    chk("div_c0_stall", stall, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      E_md_start = 1'b0;
      D_md = (c == 4);
      #2;
      chk($sformatf("div_c%0d_stall", c), stall, (c == 4));
      chk($sformatf("div_c%0d_busy", c), md_busy, (c <= 10));
      chk($sformatf("div_c%0d_done", c), md_done, (c == 11));
    end

    // Reset during a div at busy cycle 3.
    @(negedge clk);
    D_md = 1'b0; E_md_start = 1'b1; E_md_op = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      E_md_start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    D_md  = 1'b1;
    #2;
    chk("rstdiv_busy_before_edge", md_busy, 1'b1);
    chk("rstdiv_stall_in_reset", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("rstdiv_busy_cleared", md_busy, 1'b0);
    chk("rstdiv_stall_after", stall, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #2;
      chk($sformatf("rstdiv_nodone%0d", c), md_done, 1'b0);
      chk($sformatf("rstdiv_idle%0d", c), md_busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
